// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier
//   Iterative radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, one Booth digit
//   per clock. Signed or unsigned operation is chosen per request.
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        request, accepted only while ready=1
//   signed_mode  1: operands are two's complement, 0: unsigned (sampled with start)
//   a, b         multiplicand / multiplier (sampled on the accepting edge)
//   ready        block can accept start this cycle
//   busy         operation in progress
//   done         one-cycle pulse, product valid
//   product      last result, held until the next done or reset
module booth_seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;      // product width
  localparam int unsigned E  = WIDTH + 2;      // extended operand width
  localparam int unsigned N  = WIDTH / 2 + 1;  // Booth digits = RUN cycles
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
    $error("booth_seq_multiplier: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_nx;
  logic          accept;
  logic          ready_nx;
  logic          busy_nx;
  logic          done_nx;
  logic [CW-1:0] cnt;
  logic [E:0]    mq;      // extended multiplier with b[-1] appended, shifted right 2/cycle
  logic [PW-1:0] mcand;   // extended multiplicand, pre-scaled by 4^i
  logic [PW-1:0] acc;
  logic [PW-1:0] pp;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode, registered below so outputs track the state being entered
  always_comb begin
    ready_nx = 1'b1;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    if (state_nx == RUN) begin
      ready_nx = 1'b0;
      busy_nx  = 1'b1;
    end
    if (state == DONE) done_nx = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ready <= ready_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  assign accept = start && (state == IDLE || state == DONE);

  // Booth digit select: multiple of the scaled multiplicand for this digit
  always_comb begin
    pp = '0;
    case (mq[2:0])
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
  end

  // Datapath. Bits of the 2*E accumulator above 2*WIDTH never reach product,
  // so all arithmetic is carried modulo 2^(2*WIDTH).
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      mcand   <= '0;
      mq      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      if (state == DONE) product <= acc;
      if (accept) begin
        mcand <= signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        mq    <= signed_mode ? {b[WIDTH-1], b[WIDTH-1], b, 1'b0} : {2'b00, b, 1'b0};
        acc   <= '0;
        cnt   <= '0;
      end else if (state == RUN) begin
        acc   <= acc + pp;
        mcand <= mcand << 2;
        mq    <= mq >> 2;
        cnt   <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier
//   Self-checking bench for booth_seq_multiplier: WIDTH=32 and WIDTH=8 instances,
//   directed vector table, handshake corner sequences and random operands compared
//   against plain integer multiplication.
module tb_booth_seq_multiplier;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] product;

  logic        start8;
  logic        signed_mode8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        ready8;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  int n_cmp = 0;
  int n_bad = 0;

  booth_seq_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .ready(ready), .busy(busy), .done(done), .product(product)
  );

  booth_seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(signed_mode8),
    .a(a8), .b(b8), .ready(ready8), .busy(busy8), .done(done8), .product(product8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          width;
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: exact integer product, truncated to 2*WIDTH bits
  function automatic logic [63:0] model32(input logic [31:0] x, input logic [31:0] y, input logic sm);
    longint xs, ys;
    xs = sm ? longint'($signed(x)) : longint'({32'b0, x});
    ys = sm ? longint'($signed(y)) : longint'({32'b0, y});
    return 64'(xs * ys);
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic sm);
    int xs, ys;
    xs = sm ? int'($signed(x)) : int'({24'b0, x});
    ys = sm ? int'($signed(y)) : int'({24'b0, y});
    return 16'(xs * ys);
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] rnd8();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  // One complete operation on the 32-bit instance, with latency and pulse-width checks
  task automatic op32(input logic [31:0] ta, input logic [31:0] tb_, input logic tsm,
                      input logic [63:0] exp, input string nm);
    int lat;
    bit seen;
    @(negedge clk);
    check({nm, "/ready"}, 64'(ready), 64'd1);
    a = ta; b = tb_; signed_mode = tsm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; signed_mode = ~tsm;
    check({nm, "/busy"}, 64'({busy, ready}), 64'b10);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
    check({nm, "/done_seen"}, 64'(seen), 64'd1);
    check({nm, "/latency"}, 64'(lat), 64'd18);
    check({nm, "/product"}, product, exp);
    @(posedge clk); #1;
    check({nm, "/pulse"}, 64'({done, ready}), 64'b01);
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tsm,
                     input logic [15:0] exp, input string nm);
    int lat;
    bit seen;
    @(negedge clk);
    check({nm, "/ready8"}, 64'(ready8), 64'd1);
    a8 = ta; b8 = tb_; signed_mode8 = tsm; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); signed_mode8 = ~tsm;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done8) seen = 1'b1;
    end
    check({nm, "/done_seen8"}, 64'(seen), 64'd1);
    check({nm, "/latency8"}, 64'(lat), 64'd6);
    check({nm, "/product8"}, 64'(product8), 64'(exp));
    @(posedge clk); #1;
    check({nm, "/pulse8"}, 64'(done8), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [31:0] ra, rb;
    logic [7:0]  ra8, rb8;
    logic        rsm;

    vecs.push_back('{32, 32'h0008_7234, 32'h0000_0348, 1'b1, 64'h0000_0000_1BB6_BAA0});
    vecs.push_back('{32, 32'h0008_7234, 32'hFFFF_FEFD, 1'b1, 64'hFFFF_FFFF_F774_7564});
    vecs.push_back('{32, 32'hFFFF_FEFD, 32'hFFFF_FEFD, 1'b1, 64'h0000_0000_0001_0609});
    vecs.push_back('{32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001});
    vecs.push_back('{32, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000});
    vecs.push_back('{32, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000});
    vecs.push_back('{32, 32'h0000_0000, 32'h1234_5678, 1'b1, 64'h0});
    vecs.push_back('{32, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 64'h0});
    vecs.push_back('{32, 32'h0000_0001, 32'hB887_CAAF, 1'b1, 64'hFFFF_FFFF_B887_CAAF});
    vecs.push_back('{32, 32'h0000_0001, 32'hB887_CAAF, 1'b0, 64'h0000_0000_B887_CAAF});
    vecs.push_back('{8,  32'h80, 32'h80, 1'b1, 64'h4000});
    vecs.push_back('{8,  32'hFF, 32'hFF, 1'b0, 64'hFE01});
    vecs.push_back('{8,  32'hFF, 32'hFF, 1'b1, 64'h0001});
    vecs.push_back('{8,  32'h7F, 32'h81, 1'b1, 64'hC0FF});

    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    start8 = 1'b0; signed_mode8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/flags", 64'({ready, busy, done}), 64'b100);
    check("reset/product", product, 64'h0);
    check("reset/flags8", 64'({ready8, busy8, done8}), 64'b100);
    check("reset/product8", 64'(product8), 64'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].width == 32)
        op32(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, $sformatf("vec%0d", i));
      else
        op8(vecs[i].a[7:0], vecs[i].b[7:0], vecs[i].sm, vecs[i].exp[15:0], $sformatf("vec%0d", i));
    end

    // start and operand changes while busy are ignored, not queued
    @(negedge clk);
    a = 32'h0008_7234; b = 32'h0000_0348; signed_mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 3) begin start = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; signed_mode = 1'b0; end
      if (cyc == 10) start = 1'b0;
      if (cyc == 18) begin
        check("ignore/done", 64'(done), 64'd1);
        check("ignore/product", product, 64'h1BB6_BAA0);
      end else if (done) ndone++;
    end
    check("ignore/extra_done", 64'(ndone), 64'd0);
    check("ignore/product_hold", product, 64'h1BB6_BAA0);

    // start held high: results back to back every 18 cycles
    @(negedge clk);
    a = 32'h0008_7234; b = 32'h0000_0348; signed_mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; signed_mode = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      check($sformatf("b2b/done@%0d", cyc), 64'(done),
            64'((cyc == 18) || (cyc == 36) || (cyc == 54)));
      if (cyc == 18) begin
        check("b2b/product0", product, 64'h1BB6_BAA0);
        signed_mode = 1'b1;
      end
      if (cyc == 36) begin
        check("b2b/product1", product, 64'hFFFF_FFFE_0000_0001);
        start = 1'b0;
      end
      if (cyc == 54) check("b2b/product2", product, 64'h1);
    end

    // reset in the middle of RUN aborts without a done pulse
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h9ABC_DEF0; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort/busy", 64'({busy, ready}), 64'b10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort/flags", 64'({ready, busy, done}), 64'b100);
    check("abort/product", product, 64'h0);
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort/no_done", 64'(ndone), 64'd0);

    // random operands against the integer reference
    for (int i = 0; i < 120; i++) begin
      ra = rnd32(); rb = rnd32(); rsm = 1'($urandom);
      op32(ra, rb, rsm, model32(ra, rb, rsm), $sformatf("rnd32_%0d", i));
      ra8 = rnd8(); rb8 = rnd8(); rsm = 1'($urandom);
      op8(ra8, rb8, rsm, model8(ra8, rb8, rsm), $sformatf("rnd8_%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
